// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one-cycle-latency memory reads,
// parks in-flight responses in a one-entry skid buffer across stalls and loads IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        Branch_Sig_in,
  input  logic [31:0] PC_target,
  output logic [31:0] iaddr,
  output logic        ireq,
  input  logic [31:0] inst_in,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_PC,
  output logic        ifid_valid
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  logic [31:0] fpc_q, fpc_d;
  logic        rsp_v_q, rsp_v_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic        skid_v_q, skid_v_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;

  logic redirect;

  // A redirect presented while stalled is ignored; the resolver re-presents it.
  assign redirect = !stall && Branch_Sig_in;

  assign iaddr      = fpc_q;
  assign ireq       = !rst && !stall;
  assign ifid_inst  = ifid_inst_q;
  assign ifid_PC    = ifid_pc_q;
  assign ifid_valid = ifid_valid_q;

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block leaves a
    // signal unassigned, which would otherwise infer a latch.
    fpc_d        = fpc_q;
    rsp_v_d      = rsp_v_q;
    rsp_pc_d     = rsp_pc_q;
    skid_v_d     = skid_v_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_pc_d    = ifid_pc_q;

    if (redirect) begin
      // Both the response arriving now and the fetch issued now are wrong-path.
      fpc_d        = PC_target & 32'hFFFF_FFFC;
      rsp_v_d      = 1'b0;
      skid_v_d     = 1'b0;
      ifid_valid_d = 1'b0;
    end else if (stall) begin
      if (rsp_v_q) begin
        skid_v_d    = 1'b1;
        skid_inst_d = inst_in;
        skid_pc_d   = rsp_pc_q;
      end
      rsp_v_d = 1'b0;
    end else begin
      fpc_d    = fpc_q + STEP;
      rsp_v_d  = 1'b1;
      rsp_pc_d = fpc_q;
      if (skid_v_q) begin
        ifid_valid_d = 1'b1;
        ifid_inst_d  = skid_inst_q;
        ifid_pc_d    = skid_pc_q + STEP;
        skid_v_d     = 1'b0;
      end else if (rsp_v_q) begin
        ifid_valid_d = 1'b1;
        ifid_inst_d  = inst_in;
        ifid_pc_d    = rsp_pc_q + STEP;
      end else begin
        ifid_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    if (rst) begin
      fpc_q        <= RESET_PC;
      rsp_v_q      <= 1'b0;
      skid_v_q     <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_inst_q  <= '0;
      ifid_pc_q    <= '0;
    end else begin
      fpc_q        <= fpc_d;
      rsp_v_q      <= rsp_v_d;
      skid_v_q     <= skid_v_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc_q    <= ifid_pc_d;
    end
  end

  // NOTE: payload registers carry no reset; they are only ever read behind a
  // valid bit that is itself reset, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    rsp_pc_q    <= rsp_pc_d;
    skid_inst_q <= skid_inst_d;
    skid_pc_q   <= skid_pc_d;
  end

  // The skid buffer only fills during a stall, when no new fetch is outstanding.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(rsp_v_q && skid_v_q))
        else $error("skid buffer and response valid both set");
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory model returns word = address, one-cycle latency.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] inst_in = '0;
  logic [31:0] iaddr;
  logic        ireq;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc;
  logic        ifid_valid;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .Branch_Sig_in(br),
    .PC_target    (tgt),
    .iaddr        (iaddr),
    .ireq         (ireq),
    .inst_in      (inst_in),
    .ifid_inst    (ifid_inst),
    .ifid_PC      (ifid_pc),
    .ifid_valid   (ifid_valid)
  );

  // Synchronous instruction memory: data for a request appears the following cycle.
  always @(posedge clk) begin
    if (ireq) inst_in <= iaddr;
  end

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        chk;
    logic [31:0] e_iaddr;
    logic        e_ireq;
    logic        e_valid;
    logic        chk_data;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic b, input logic [31:0] t,
                     input logic chk, input logic [31:0] ea, input logic er, input logic ev,
                     input logic cd, input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.tgt = t; v.chk = chk;
    v.e_iaddr = ea; v.e_ireq = er; v.e_valid = ev;
    v.chk_data = cd; v.e_inst = ei; v.e_pc = ep;
    vecs.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] t);
    @(negedge clk);
    rst = r; stall = s; br = b; tgt = t;
    #1;
  endtask

  task automatic expect_cycle(input logic [31:0] ea, input logic er, input logic ev,
                              input logic cd, input logic [31:0] ei, input logic [31:0] ep);
    check($sformatf("c%0d iaddr", cyc), iaddr, ea);
    check($sformatf("c%0d ireq", cyc), {31'b0, ireq}, {31'b0, er});
    check($sformatf("c%0d ifid_valid", cyc), {31'b0, ifid_valid}, {31'b0, ev});
    if (cd) begin
      check($sformatf("c%0d ifid_inst", cyc), ifid_inst, ei);
      check($sformatf("c%0d ifid_PC", cyc), ifid_pc, ep);
    end
    cyc++;
  endtask

  initial begin
    // rst st br tgt           chk iaddr      ireq vld cd inst       pc
    add(1, 0, 0, 32'h0,        0, 32'h0,     0, 0, 0, 32'h0,     32'h0);
    add(1, 0, 0, 32'h0,        1, 32'h0,     0, 0, 1, 32'h0,     32'h0);
    add(0, 0, 0, 32'h0,        1, 32'h0,     1, 0, 0, 32'h0,     32'h0);
    add(0, 0, 0, 32'h0,        1, 32'h4,     1, 0, 0, 32'h0,     32'h0);
    add(0, 0, 0, 32'h0,        1, 32'h8,     1, 1, 1, 32'h0,     32'h4);
    add(0, 0, 0, 32'h0,        1, 32'hC,     1, 1, 1, 32'h4,     32'h8);
    // three-cycle stall while fetching 0x10
    add(0, 1, 0, 32'h0,        1, 32'h10,    0, 1, 1, 32'h8,     32'hC);
    add(0, 1, 0, 32'h0,        1, 32'h10,    0, 1, 1, 32'h8,     32'hC);
    add(0, 1, 0, 32'h0,        1, 32'h10,    0, 1, 1, 32'h8,     32'hC);
    add(0, 0, 0, 32'h0,        1, 32'h10,    1, 1, 1, 32'h8,     32'hC);
    add(0, 0, 0, 32'h0,        1, 32'h14,    1, 1, 1, 32'hC,     32'h10);
    add(0, 0, 0, 32'h0,        1, 32'h18,    1, 1, 1, 32'h10,    32'h14);
    add(0, 0, 0, 32'h0,        1, 32'h1C,    1, 1, 1, 32'h14,    32'h18);
    // redirect to 0x103 (aligned to 0x100) while fetching 0x20
    add(0, 0, 1, 32'h103,      1, 32'h20,    1, 1, 1, 32'h18,    32'h1C);
    add(0, 0, 0, 32'h0,        1, 32'h100,   1, 0, 0, 32'h0,     32'h0);
    add(0, 0, 0, 32'h0,        1, 32'h104,   1, 0, 0, 32'h0,     32'h0);
    add(0, 0, 0, 32'h0,        1, 32'h108,   1, 1, 1, 32'h100,   32'h104);
    // redirect while stalled is ignored
    add(0, 1, 1, 32'h200,      1, 32'h10C,   0, 1, 1, 32'h104,   32'h108);
    add(0, 1, 0, 32'h0,        1, 32'h10C,   0, 1, 1, 32'h104,   32'h108);
    add(0, 0, 0, 32'h0,        1, 32'h10C,   1, 1, 1, 32'h104,   32'h108);
    add(0, 0, 0, 32'h0,        1, 32'h110,   1, 1, 1, 32'h108,   32'h10C);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt);
      if (vecs[i].chk) begin
        expect_cycle(vecs[i].e_iaddr, vecs[i].e_ireq, vecs[i].e_valid,
                     vecs[i].chk_data, vecs[i].e_inst, vecs[i].e_pc);
      end else begin
        cyc++;
      end
    end

    // Stall fills the skid, then a redirect on the first unstalled cycle flushes it.
    drive(0, 1, 0, 32'h0);    expect_cycle(32'h114, 0, 1, 1, 32'h10C, 32'h110);
    drive(0, 1, 0, 32'h0);    expect_cycle(32'h114, 0, 1, 1, 32'h10C, 32'h110);
    drive(0, 0, 1, 32'h300);  expect_cycle(32'h114, 1, 1, 1, 32'h10C, 32'h110);
    drive(0, 0, 0, 32'h0);    expect_cycle(32'h300, 1, 0, 0, 32'h0, 32'h0);
    drive(0, 0, 0, 32'h0);    expect_cycle(32'h304, 1, 0, 0, 32'h0, 32'h0);

    // Redirect to the top word: fetch PC and link PC both wrap to zero.
    drive(0, 0, 1, 32'hFFFF_FFFC); expect_cycle(32'h308, 1, 1, 1, 32'h300, 32'h304);
    drive(0, 0, 0, 32'h0);    expect_cycle(32'hFFFF_FFFC, 1, 0, 0, 32'h0, 32'h0);
    drive(0, 0, 0, 32'h0);    expect_cycle(32'h0, 1, 0, 0, 32'h0, 32'h0);

    // Reset asserted during a stall with the skid buffer full.
    drive(0, 1, 0, 32'h0);    expect_cycle(32'h4, 0, 1, 1, 32'hFFFF_FFFC, 32'h0);
    drive(1, 1, 0, 32'h0);    expect_cycle(32'h4, 0, 1, 1, 32'hFFFF_FFFC, 32'h0);
    drive(0, 0, 0, 32'h0);    expect_cycle(32'h0, 1, 0, 1, 32'h0, 32'h0);
    drive(0, 0, 0, 32'h0);    expect_cycle(32'h4, 1, 0, 0, 32'h0, 32'h0);
    drive(0, 0, 0, 32'h0);    expect_cycle(32'h8, 1, 1, 1, 32'h0, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
